// File: rtl/bin_to_gray_counter.sv
// Binary counter with a registered Gray-code output and a one-cycle wrap pulse.
// Define GRAY_COUNTER_DOWN_EN to add the 'dir' port for down counting.
module bin_to_gray_counter #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inc,
  input  logic                  load,
`ifdef GRAY_COUNTER_DOWN_EN
  input  logic                  dir,
`endif
  input  logic [DATA_WIDTH-1:0] load_bin,
  output logic [DATA_WIDTH-1:0] bin,
  output logic [DATA_WIDTH-1:0] gray,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_width_check
    $error("bin_to_gray_counter: DATA_WIDTH must be in 2..32");
  end

  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic                  wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = load_bin;
    end else if (inc) begin
`ifdef GRAY_COUNTER_DOWN_EN
      if (dir) begin
        cnt_d  = cnt_q - ONE;
        wrap_d = (cnt_q == ZERO);
      end else begin
        cnt_d  = cnt_q + ONE;
        wrap_d = (cnt_q == ALL_ONES);
      end
`else
      cnt_d  = cnt_q + ONE;
      wrap_d = (cnt_q == ALL_ONES);
`endif
    end
  end

  // Gray is encoded from the next count so the output comes straight off a flop.
  assign gray_d = cnt_d ^ (cnt_d >> 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= ZERO;
      gray_q <= ZERO;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = cnt_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Directed bench for bin_to_gray_counter at widths 16, 4 and 8 sharing one stimulus.
module tb_bin_to_gray_counter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inc;
  logic        load;
  logic [31:0] load_bin;
`ifdef GRAY_COUNTER_DOWN_EN
  logic        dir;
`endif

  logic [15:0] bin16, gray16;
  logic [3:0]  bin4, gray4;
  logic [7:0]  bin8, gray8;
  logic        wrap16, wrap4, wrap8;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  bin_to_gray_counter #(.DATA_WIDTH(16)) u_w16 (
    .clk(clk), .resetn(resetn), .inc(inc), .load(load),
`ifdef GRAY_COUNTER_DOWN_EN
    .dir(dir),
`endif
    .load_bin(load_bin[15:0]), .bin(bin16), .gray(gray16), .wrap(wrap16));

  bin_to_gray_counter #(.DATA_WIDTH(4)) u_w4 (
    .clk(clk), .resetn(resetn), .inc(inc), .load(load),
`ifdef GRAY_COUNTER_DOWN_EN
    .dir(dir),
`endif
    .load_bin(load_bin[3:0]), .bin(bin4), .gray(gray4), .wrap(wrap4));

  bin_to_gray_counter #(.DATA_WIDTH(8)) u_w8 (
    .clk(clk), .resetn(resetn), .inc(inc), .load(load),
`ifdef GRAY_COUNTER_DOWN_EN
    .dir(dir),
`endif
    .load_bin(load_bin[7:0]), .bin(bin8), .gray(gray8), .wrap(wrap8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prev_bin;
    logic [7:0] prev_gray;
    logic [7:0] exp_bin;
    int         wraps;

    resetn   = 1'b0;
    inc      = 1'b0;
    load     = 1'b0;
    load_bin = 32'h0;
`ifdef GRAY_COUNTER_DOWN_EN
    dir      = 1'b0;
`endif
    #1;
    check("reset_bin16", bin16, 32'h0);
    check("reset_gray16", gray16, 32'h0);
    check("reset_wrap16", wrap16, 32'h0);

    // inputs ignored while held in reset
    inc = 1'b1; load = 1'b1; load_bin = 32'h0000_1234;
    step();
    check("in_reset_bin16", bin16, 32'h0);
    check("in_reset_gray16", gray16, 32'h0);
    inc = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    step();
    check("load_bin16", bin16, 32'h1234);
    check("load_gray16", gray16, 32'h1B2E);
    load = 1'b0;

    // asynchronous reset mid-cycle
    #3 resetn = 1'b0;
    #1;
    check("async_rst_bin16", bin16, 32'h0);
    check("async_rst_gray16", gray16, 32'h0);
    check("async_rst_wrap16", wrap16, 32'h0);
    check("async_rst_bin4", bin4, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // up count from reset, width 4
    check("up0_gray4", gray4, 32'h0);
    inc = 1'b1;
    step(); check("up1_bin4", bin4, 32'd1); check("up1_gray4", gray4, 32'b0001);
    step(); check("up2_bin4", bin4, 32'd2); check("up2_gray4", gray4, 32'b0011);
    step(); check("up3_bin4", bin4, 32'd3); check("up3_gray4", gray4, 32'b0010);
    step(); check("up4_bin4", bin4, 32'd4); check("up4_gray4", gray4, 32'b0110);
    check("up4_wrap4", wrap4, 32'h0);

    // wrap from all-ones
    inc = 1'b0; load = 1'b1; load_bin = 32'd15;
    step(); check("ld15_bin4", bin4, 32'd15); check("ld15_gray4", gray4, 32'b1000);
    load = 1'b0; inc = 1'b1;
    step();
    check("wrap_bin4", bin4, 32'd0);
    check("wrap_gray4", gray4, 32'b0000);
    check("wrap_pulse4", wrap4, 32'h1);
    inc = 1'b0;
    step();
    check("wrap_gone4", wrap4, 32'h0);
    check("hold_after_wrap_bin4", bin4, 32'd0);

    // load beats inc
    load = 1'b1; inc = 1'b1; load_bin = 32'd10;
    step();
    check("prio_bin4", bin4, 32'd10);
    check("prio_gray4", gray4, 32'b1111);
    check("prio_wrap4", wrap4, 32'h0);
    load_bin = 32'd15; inc = 1'b0;
    step();
    inc = 1'b1; load_bin = 32'd3;
    step();
    check("prio_ones_bin4", bin4, 32'd3);
    check("prio_ones_gray4", gray4, 32'b0010);
    check("prio_ones_wrap4", wrap4, 32'h0);

    // hold
    load = 1'b0; inc = 1'b0;
    step(); step();
    check("hold_bin4", bin4, 32'd3);
    check("hold_gray4", gray4, 32'b0010);
    check("hold_wrap4", wrap4, 32'h0);

    // exhaustive 512 back-to-back increments, width 8
    resetn = 1'b0;
    #2 resetn = 1'b1;
    @(negedge clk);
    check("ex_start_bin8", bin8, 32'h0);
    wraps     = 0;
    exp_bin   = 8'h00;
    prev_bin  = bin8;
    prev_gray = gray8;
    inc = 1'b1;
    for (int k = 0; k < 512; k++) begin
      step();
      exp_bin = exp_bin + 8'h01;
      check("ex_bin8", bin8, exp_bin);
      check("ex_gray8", gray8, exp_bin ^ (exp_bin >> 1));
      check("ex_onebit8", $countones(gray8 ^ prev_gray), 32'd1);
      check("ex_wrap8", wrap8, (prev_bin == 8'hFF) ? 32'h1 : 32'h0);
      if (wrap8 === 1'b1) wraps++;
      prev_bin  = bin8;
      prev_gray = gray8;
    end
    inc = 1'b0;
    check("ex_wrap_count8", wraps, 32'd2);

`ifdef GRAY_COUNTER_DOWN_EN
    resetn = 1'b0;
    #2 resetn = 1'b1;
    @(negedge clk);
    dir = 1'b1; inc = 1'b1;
    step();
    check("down1_bin4", bin4, 32'd15);
    check("down1_gray4", gray4, 32'b1000);
    check("down1_wrap4", wrap4, 32'h1);
    step();
    check("down2_bin4", bin4, 32'd14);
    check("down2_gray4", gray4, 32'b1001);
    check("down2_wrap4", wrap4, 32'h0);
    inc = 1'b0; dir = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin_to_gray_counter.md
BIN_TO_GRAY_COUNTER -- requirements
Module: bin_to_gray_counter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the binary count and the Gray output; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 inc  input  1  advance the count by one step this cycle.
REQ-005 load  input  1  replace the count with load_bin this cycle.
REQ-006 load_bin  input  DATA_WIDTH  binary value to load.
REQ-007 bin  output  DATA_WIDTH  current binary count, registered.
REQ-008 gray  output  DATA_WIDTH  Gray encoding of bin, driven directly from a flop, with no logic after the flop.
REQ-009 wrap  output  1  one-cycle pulse on a count wrap-around, registered.

Function
REQ-010 Internal binary register cnt; bin SHALL equal cnt.
REQ-011 gray SHALL always equal bin XOR (bin >> 1) in the same cycle as bin.
- The Gray value is computed from the next value of cnt and registered alongside it.
- It is not decoded from bin after the flop.
REQ-012 Priority per cycle: load > inc > hold.
REQ-013 load=1: on the next edge cnt <= load_bin and gray <= Gray(load_bin); inc is ignored; wrap <= 0.
REQ-014 load=0, inc=1: on the next edge cnt <= (cnt + 1) mod 2^DATA_WIDTH and gray <= Gray of the new cnt.
REQ-015 load=0, inc=0: cnt, bin and gray SHALL hold their values; wrap <= 0.
REQ-016 wrap SHALL be 1 for exactly one cycle, the cycle after an increment edge that takes cnt from all-ones to zero; otherwise 0.
REQ-017 Back-to-back increments SHALL produce a new value every cycle, with zero bubble cycles.
REQ-018 Any two consecutive gray values produced by a single increment SHALL differ in exactly one bit, including the wrap from all-ones to zero.
REQ-019 A load is not required to preserve the single-bit-change property.
REQ-020 Latency: inputs sampled at edge N appear on bin/gray/wrap after edge N; there are no combinational input-to-output paths.

Reset
REQ-021 resetn=0 SHALL immediately, without waiting for a clock edge, force cnt=0, bin=0, gray=0 and wrap=0.
REQ-022 While resetn=0, inc and load SHALL be ignored.
REQ-023 After resetn deasserts, the first clock edge SHALL process inputs normally.
REQ-024 Reset asserted mid-count SHALL discard the count entirely, with no partial state retained.

Configuration
REQ-025 Macro GRAY_COUNTER_DOWN_EN, when defined, adds input port dir (1 bit).
- dir=0: inc counts up.
- dir=1: inc steps cnt to (cnt - 1) mod 2^DATA_WIDTH.
- In down mode, wrap pulses on the step from zero to all-ones.
- The up-mode all-ones-to-zero step does not pulse wrap in down mode.
- Load priority is unchanged.
REQ-026 Without GRAY_COUNTER_DOWN_EN, port dir SHALL NOT exist, the counter is up-only, and behaviour is exactly REQ-010..REQ-020.

Verification
REQ-027 Reset: assert resetn=0 asynchronously mid-cycle with cnt=0x1234 -> bin=0, gray=0, wrap=0 before the next edge.
REQ-028 Up count, DATA_WIDTH=4: inc=1 for 4 cycles from reset -> gray sequence 0000, 0001, 0011, 0010, 0110; bin 0..4.
REQ-029 Wrap, DATA_WIDTH=4: load 15 then inc=1 -> bin=0, gray=0000 (from 1000), wrap=1 for one cycle only.
REQ-030 Priority: load=1, inc=1, load_bin=10 -> next cycle bin=10, gray=1111, wrap=0.
REQ-031 Exhaustive, DATA_WIDTH=8: 512 consecutive increments -> every step changes exactly one gray bit; wrap pulses exactly twice.
REQ-032 With GRAY_COUNTER_DOWN_EN, DATA_WIDTH=4: dir=1, inc=1 from 0 -> bin=15, gray=1000, wrap=1; next cycle bin=14, gray=1001, wrap=0.
